// File: rtl/lgappg_sched_if.sv
// rtl/lgappg_sched_if.sv - control, lattice-word input and window output bundle for lgappg_sched
interface lgappg_sched_if;
   logic         start;
   logic         busy;
   logic         done;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_data;
   logic         win_valid;
   logic         win_ready;
   logic [575:0] win_data;
   logic         win_odd;

   modport master (
      output start, in_valid, in_data, win_ready,
      input  busy, done, in_ready, win_valid, win_data, win_odd
   );

   modport slave (
      input  start, in_valid, in_data, win_ready,
      output busy, done, in_ready, win_valid, win_data, win_odd
   );
endinterface

// File: rtl/lgappg_sched.sv
// rtl/lgappg_sched.sv - 3x3 word-window scheduler with wall boundary for the lattice-gas datapath
module lgappg_sched #(
   parameter int W_WORDS = 8,
   parameter int H_ROWS  = 8
) (
   input logic         clk,
   input logic         rst,
   lgappg_sched_if.slave bus
);
   localparam int NW = W_WORDS * H_ROWS;
   localparam int S  = 2 * W_WORDS + 3;
   localparam int CW = $clog2(NW + 1);
   localparam int FW = $clog2(W_WORDS + 2);
   localparam int XW = $clog2(W_WORDS);
   localparam int YW = $clog2(H_ROWS);

   localparam logic [CW-1:0] LAST_IDX   = CW'(NW - 1);
   localparam logic [CW-1:0] FIRST_LOAD = CW'(W_WORDS + 1);
   localparam logic [FW-1:0] FL_END     = FW'(W_WORDS + 1);
   localparam logic [XW-1:0] X_LAST     = XW'(W_WORDS - 1);
   localparam logic [YW-1:0] Y_LAST     = YW'(H_ROWS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   in_cnt_q, in_cnt_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [FW-1:0]   fl_cnt_q, fl_cnt_d;
   logic [XW-1:0]   col_q, col_d;
   logic [YW-1:0]   row_q, row_d;
   logic [63:0]     store_q [S];
   logic [63:0]     store_d [S];
   logic [63:0]     store_nx [S];
   logic [575:0]    win_data_q, win_data_d;
   logic            win_valid_q, win_valid_d;
   logic            win_odd_q, win_odd_d;
   logic [575:0]    win_nx;

   logic slot_free, acc, fl_shift, hs, load;

   // store_nx is the store after this cycle's shift; index j holds the word shifted in j steps ago
   always_comb begin
      slot_free = !win_valid_q || bus.win_ready;
      acc       = (state_q == RUN) && bus.in_valid && slot_free;
      fl_shift  = (state_q == FLUSH) && (fl_cnt_q != FL_END) && slot_free;
      hs        = win_valid_q && bus.win_ready;
      load      = (acc && (in_cnt_q >= FIRST_LOAD)) || fl_shift;
      store_nx[0] = (state_q == RUN) ? bus.in_data : 64'd0;
      for (int j = 1; j < S; j++) begin
         store_nx[j] = store_q[j-1];
      end
   end

   // The centre of the window being loaded sits at store index W_WORDS+1; (row_q, col_q) track it
   for (genvar k = 0; k < 9; k++) begin : g_win
      localparam int  DR = k / 3 - 1;
      localparam int  DC = k % 3 - 1;
      localparam int  J  = W_WORDS + 1 - (DR * W_WORDS + DC);
      localparam bit  UP = (DR < 0);
      localparam bit  DN = (DR > 0);
      localparam bit  LF = (DC < 0);
      localparam bit  RT = (DC > 0);
      logic wall;
      assign wall = (UP && (row_q == '0)) || (DN && (row_q == Y_LAST)) ||
                    (LF && (col_q == '0)) || (RT && (col_q == X_LAST));
      assign win_nx[64*k +: 64] = wall ? 64'd0 : store_nx[J];
   end

   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      fl_cnt_d    = fl_cnt_q;
      col_d       = col_q;
      row_d       = row_q;
      store_d     = store_q;
      win_data_d  = win_data_q;
      win_valid_d = win_valid_q;
      win_odd_d   = win_odd_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = RUN;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               fl_cnt_d  = '0;
               col_d     = '0;
               row_d     = '0;
               for (int j = 0; j < S; j++) begin
                  store_d[j] = 64'd0;
               end
            end
         end
         RUN: begin
            if (acc && (in_cnt_q == LAST_IDX)) state_d = FLUSH;
         end
         FLUSH: begin
            if (hs && (out_cnt_q == LAST_IDX)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (acc)      in_cnt_d  = in_cnt_q + CW'(1);
      if (fl_shift) fl_cnt_d  = fl_cnt_q + FW'(1);
      if (hs)       out_cnt_d = out_cnt_q + CW'(1);
      if (acc || fl_shift) store_d = store_nx;

      if (load) begin
         win_data_d  = win_nx;
         win_valid_d = 1'b1;
         win_odd_d   = row_q[0];
         if (col_q == X_LAST) begin
            col_d = '0;
            row_d = (row_q == Y_LAST) ? '0 : row_q + YW'(1);
         end else begin
            col_d = col_q + XW'(1);
         end
      end else if (hs) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         fl_cnt_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         win_data_q  <= '0;
         win_valid_q <= 1'b0;
         win_odd_q   <= 1'b0;
         for (int j = 0; j < S; j++) begin
            store_q[j] <= 64'd0;
         end
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         fl_cnt_q    <= fl_cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         win_data_q  <= win_data_d;
         win_valid_q <= win_valid_d;
         win_odd_q   <= win_odd_d;
         store_q     <= store_d;
      end
   end

   assign bus.in_ready  = (state_q == RUN) && slot_free;
   assign bus.busy      = (state_q == RUN) || (state_q == FLUSH);
   assign bus.done      = (state_q == DONE);
   assign bus.win_valid = win_valid_q;
   assign bus.win_data  = win_data_q;
   assign bus.win_odd   = win_odd_q;
endmodule

// File: tb/tb_lgappg_sched.sv
// tb/tb_lgappg_sched.sv - directed-vector bench for lgappg_sched on a 4x3 lattice
module tb_lgappg_sched;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int NW = W * H;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lgappg_sched_if bus ();

   lgappg_sched #(.W_WORDS(W), .H_ROWS(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [63:0] base, input int idx);
      return base + 64'(idx) + 64'd1;
   endfunction

   // Reference window: direct (row, col) lookup into the frame, walls read as zero
   function automatic logic [575:0] model_win(input int p, input logic [63:0] base);
      logic [575:0] w;
      int r, c;
      w = '0;
      for (int k = 0; k < 9; k++) begin
         r = p / W + k / 3 - 1;
         c = p % W + k % 3 - 1;
         if (r >= 0 && r < H && c >= 0 && c < W) w[64*k +: 64] = word_of(base, r * W + c);
      end
      return w;
   endfunction

   function automatic logic v_pat(input int mode, input int cyc);
      logic [15:0] pat;
      pat = 16'b1101_1011_0111_0101;
      return (mode == 2) ? pat[cyc % 16] : 1'b1;
   endfunction

   function automatic logic r_pat(input int mode, input int cyc);
      logic [15:0] pat;
      pat = 16'b1011_1100_1110_0110;
      if (mode == 2) return pat[cyc % 16];
      if (mode == 1) return !(cyc >= 8 && cyc < 13);
      return 1'b1;
   endfunction

   // mode 0: full rate, 1: 5-cycle output stall, 2: gapped handshakes, 3: stray start and in_valid
   task automatic run_frame(input int mode, input logic [63:0] base);
      int in_idx = 0, out_idx = 0, cyc = 0, done_cnt = 0, acc6 = -1, first_v = -1;
      logic [575:0] held = '0;
      logic [575:0] e;
      logic stalled = 1'b0;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      chk("busy_after_start", bus.busy, 1);
      while (done_cnt == 0 && cyc < 400) begin
         bus.in_valid  = (mode == 3) ? 1'b1 : ((in_idx < NW) && v_pat(mode, cyc));
         bus.in_data   = (in_idx < NW) ? word_of(base, in_idx) : 64'hdead_beef_0bad_f00d;
         bus.win_ready = r_pat(mode, cyc);
         bus.start     = (mode == 3) && (cyc == 6);
         @(negedge clk);
         if (stalled) chk("stall_hold", bus.win_data, held);
         stalled = bus.win_valid && !bus.win_ready;
         held    = bus.win_data;
         if (stalled && mode == 1) chk("stall_in_ready", bus.in_ready, 0);
         if (bus.win_valid && first_v < 0) first_v = cyc;
         if (bus.in_valid && bus.in_ready) begin
            if (in_idx == W + 1) acc6 = cyc;
            in_idx++;
         end
         if (bus.win_valid && bus.win_ready) begin
            chk("win_data", bus.win_data, model_win(out_idx, base));
            chk("win_odd", bus.win_odd, (out_idx / W) % 2);
            if (mode == 0 && base == 64'd0) begin
               e = '0;
               if (out_idx == 0) begin
                  e[64*4 +: 64] = 64'd1; e[64*5 +: 64] = 64'd2;
                  e[64*7 +: 64] = 64'd5; e[64*8 +: 64] = 64'd6;
                  chk("p0_window", bus.win_data, e);
               end
               if (out_idx == 7) begin
                  e[64*0 +: 64] = 64'd3;  e[64*1 +: 64] = 64'd4;
                  e[64*3 +: 64] = 64'd7;  e[64*4 +: 64] = 64'd8;
                  e[64*6 +: 64] = 64'd11; e[64*7 +: 64] = 64'd12;
                  chk("p7_window", bus.win_data, e);
                  chk("p7_odd", bus.win_odd, 1);
               end
               if (out_idx == 11) chk("p11_bottom_wall", bus.win_data[575:384], 0);
            end
            out_idx++;
         end
         if (bus.done) begin
            done_cnt++;
            chk("busy_low_with_done", bus.busy, 0);
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.win_ready = 1'b0;
      bus.start     = 1'b0;
      chk("win_count", out_idx, NW);
      chk("in_count", in_idx, NW);
      chk("done_seen", done_cnt, 1);
      if (mode == 0) chk("first_window_latency", first_v, acc6 + 1);
      chk("done_one_cycle", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.win_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_win_valid", bus.win_valid, 0);
      chk("rst_win_data", bus.win_data, 0);
      chk("rst_win_odd", bus.win_odd, 0);
      rst = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", bus.in_ready, 0);
      chk("idle_no_window", bus.win_valid, 0);
      bus.in_valid = 1'b0;

      run_frame(0, 64'd0);
      run_frame(1, 64'd0);
      run_frame(2, 64'h0000_1000);

      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      bus.win_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int n = 0; n < 7; n++) begin
         bus.in_data = 64'(n + 1);
         @(posedge clk); #1;
      end
      chk("pre_reset_win_valid", bus.win_valid, 1);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midrun_rst_busy", bus.busy, 0);
      chk("midrun_rst_done", bus.done, 0);
      chk("midrun_rst_in_ready", bus.in_ready, 0);
      chk("midrun_rst_win_valid", bus.win_valid, 0);
      chk("midrun_rst_win_data", bus.win_data, 0);
      chk("midrun_rst_win_odd", bus.win_odd, 0);
      rst = 1'b0;
      bus.win_ready = 1'b0;

      run_frame(0, 64'h100);
      run_frame(3, 64'h2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
